// File: rtl/minibyte_regfile.sv
// minibyte_regfile: parametrised register file for the minibyte datapath.
// One write port and two registered read ports (operand A and B).
// A clear sequencer sweeps every entry to zero, one entry per cycle.
// Optional write-to-read forwarding is enabled by defining MINIBYTE_REGFILE_BYPASS_EN.
// Without the macro, a same-cycle read of the address being written returns
// the old contents (read-first).
module minibyte_regfile #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3,
    parameter int DEPTH  = 8
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              we_in,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] data_in,
    input  logic              rd_en_in,
    input  logic [ADDR_W-1:0] rd_a_addr,
    input  logic [ADDR_W-1:0] rd_b_addr,
    input  logic              clr_in,
    output logic [DATA_W-1:0] data_a_out,
    output logic [DATA_W-1:0] data_b_out,
    output logic              rd_valid_out,
    output logic              busy_out
);

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    localparam logic [ADDR_W-1:0] LastIdx = ADDR_W'(DEPTH - 1);

    state_t            r_state;
    logic [ADDR_W-1:0] r_sweepIdx;
    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_dataA;
    logic [DATA_W-1:0] r_dataB;
    logic              r_valid;
    logic              r_busy;

    logic              w_wrInRange;
    logic              w_rdAInRange;
    logic              w_rdBInRange;
    logic              w_doWrite;
    logic              w_doRead;
    logic [DATA_W-1:0] w_rdA;
    logic [DATA_W-1:0] w_rdB;

    assign w_wrInRange  = (int'(wr_addr)   < DEPTH);
    assign w_rdAInRange = (int'(rd_a_addr) < DEPTH);
    assign w_rdBInRange = (int'(rd_b_addr) < DEPTH);

    // A clear request in IDLE pre-empts any write or read issued alongside it
    assign w_doWrite = (r_state == IDLE) && we_in    && !clr_in && w_wrInRange;
    assign w_doRead  = (r_state == IDLE) && rd_en_in && !clr_in;

    // Port read muxes; out-of-range addresses read as zero, optionally forwarding the write
    always_comb begin
        w_rdA = '0;
        w_rdB = '0;
        if (w_rdAInRange) begin
            w_rdA = r_mem[rd_a_addr];
        end
        if (w_rdBInRange) begin
            w_rdB = r_mem[rd_b_addr];
        end
`ifdef MINIBYTE_REGFILE_BYPASS_EN
        if (w_doWrite && (wr_addr == rd_a_addr)) begin
            w_rdA = data_in;
        end
        if (w_doWrite && (wr_addr == rd_b_addr)) begin
            w_rdB = data_in;
        end
`endif
    end

    // Control FSM: IDLE serves reads, CLEAR walks the sweep index; all outputs registered
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state    <= IDLE;
            r_sweepIdx <= '0;
            r_dataA    <= '0;
            r_dataB    <= '0;
            r_valid    <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_dataA <= '0;
            r_dataB <= '0;
            r_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (clr_in) begin
                        r_state    <= CLEAR;
                        r_sweepIdx <= '0;
                        r_busy     <= 1'b1;
                    end else if (w_doRead) begin
                        r_dataA <= w_rdA;
                        r_dataB <= w_rdB;
                        r_valid <= 1'b1;
                    end
                end
                CLEAR: begin
                    if (r_sweepIdx == LastIdx) begin
                        r_state    <= IDLE;
                        r_sweepIdx <= '0;
                        r_busy     <= 1'b0;
                    end else begin
                        r_sweepIdx <= r_sweepIdx + 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Storage: reset zeroes everything, CLEAR zeroes one entry per cycle, IDLE accepts writes
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (r_state == CLEAR) begin
            r_mem[r_sweepIdx] <= '0;
        end else if (w_doWrite) begin
            r_mem[wr_addr] <= data_in;
        end
    end

    assign data_a_out   = r_dataA;
    assign data_b_out   = r_dataB;
    assign rd_valid_out = r_valid;
    assign busy_out     = r_busy;

endmodule

// File: tb/tb_minibyte_regfile.sv
// Directed testbench for minibyte_regfile: a default 8-entry instance plus a
// 6-entry instance sharing the same stimulus for out-of-range address checks.
module tb_minibyte_regfile;

    logic       clk_in = 1'b0;
    logic       rst_in = 1'b0;
    logic       we_in = 1'b0;
    logic [2:0] wr_addr = '0;
    logic [7:0] data_in = '0;
    logic       rd_en_in = 1'b0;
    logic [2:0] rd_a_addr = '0;
    logic [2:0] rd_b_addr = '0;
    logic       clr_in = 1'b0;
    logic [7:0] data_a_out, data_b_out;
    logic       rd_valid_out, busy_out;
    logic [7:0] d6A, d6B;
    logic       d6Valid, d6Busy;

    int testsRun = 0;
    int testsFailed = 0;
    logic [7:0] expCollide;

    minibyte_regfile dut (
        .clk_in(clk_in), .rst_in(rst_in), .we_in(we_in), .wr_addr(wr_addr),
        .data_in(data_in), .rd_en_in(rd_en_in), .rd_a_addr(rd_a_addr),
        .rd_b_addr(rd_b_addr), .clr_in(clr_in), .data_a_out(data_a_out),
        .data_b_out(data_b_out), .rd_valid_out(rd_valid_out), .busy_out(busy_out)
    );

    minibyte_regfile #(.DATA_W(8), .ADDR_W(3), .DEPTH(6)) dut6 (
        .clk_in(clk_in), .rst_in(rst_in), .we_in(we_in), .wr_addr(wr_addr),
        .data_in(data_in), .rd_en_in(rd_en_in), .rd_a_addr(rd_a_addr),
        .rd_b_addr(rd_b_addr), .clr_in(clr_in), .data_a_out(d6A),
        .data_b_out(d6B), .rd_valid_out(d6Valid), .busy_out(d6Busy)
    );

    always #5 clk_in = ~clk_in;

    // Drive one cycle of inputs, then wait past the rising edge so outputs settle
    task automatic applyStimulus(input logic we, input logic [2:0] wa, input logic [7:0] wd,
                                 input logic rd, input logic [2:0] ra, input logic [2:0] rb,
                                 input logic clr);
        we_in = we; wr_addr = wa; data_in = wd;
        rd_en_in = rd; rd_a_addr = ra; rd_b_addr = rb; clr_in = clr;
        @(posedge clk_in);
        #1;
    endtask

    // Compare one observed value against its hand-computed expectation
    task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        testsRun++;
        assert (observed === expected) else begin
            testsFailed++;
            $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
            $error("[TB] check %s", tag);
        end
    endtask

    task automatic doReset();
        rst_in = 1'b1;
        applyStimulus(0, 0, 8'h00, 0, 0, 0, 0);
        applyStimulus(0, 0, 8'h00, 0, 0, 0, 0);
        rst_in = 1'b0;
    endtask

    initial begin
`ifdef MINIBYTE_REGFILE_BYPASS_EN
        expCollide = 8'h22;
`else
        expCollide = 8'h11;
`endif
        // Reset state
        doReset();
        checkOutput("rst_valid", {7'd0, rd_valid_out}, 8'h00);
        checkOutput("rst_busy", {7'd0, busy_out}, 8'h00);
        checkOutput("rst_dataA", data_a_out, 8'h00);
        checkOutput("rst_dataB", data_b_out, 8'h00);

        // First read after reset
        applyStimulus(0, 0, 8'h00, 1, 3'd0, 3'd7, 0);
        checkOutput("rd0_valid", {7'd0, rd_valid_out}, 8'h01);
        checkOutput("rd0_dataA", data_a_out, 8'h00);
        checkOutput("rd0_dataB", data_b_out, 8'h00);

        // Writes followed by a dual-port read, then an idle cycle
        applyStimulus(1, 3'd3, 8'hA5, 0, 0, 0, 0);
        applyStimulus(1, 3'd5, 8'h3C, 0, 0, 0, 0);
        applyStimulus(0, 0, 8'h00, 1, 3'd3, 3'd5, 0);
        checkOutput("rd35_valid", {7'd0, rd_valid_out}, 8'h01);
        checkOutput("rd35_dataA", data_a_out, 8'hA5);
        checkOutput("rd35_dataB", data_b_out, 8'h3C);
        applyStimulus(0, 0, 8'h00, 0, 3'd3, 3'd5, 0);
        checkOutput("idle_valid", {7'd0, rd_valid_out}, 8'h00);
        checkOutput("idle_dataA", data_a_out, 8'h00);
        checkOutput("idle_dataB", data_b_out, 8'h00);

        // Same address on both ports
        applyStimulus(0, 0, 8'h00, 1, 3'd5, 3'd5, 0);
        checkOutput("same_dataA", data_a_out, 8'h3C);
        checkOutput("same_dataB", data_b_out, 8'h3C);

        // Read/write collision
        applyStimulus(1, 3'd2, 8'h11, 0, 0, 0, 0);
        applyStimulus(1, 3'd2, 8'h22, 1, 3'd2, 3'd3, 0);
        checkOutput("collide_dataA", data_a_out, expCollide);
        checkOutput("collide_dataB", data_b_out, 8'hA5);
        applyStimulus(0, 0, 8'h00, 1, 3'd2, 3'd2, 0);
        checkOutput("after_collide", data_a_out, 8'h22);

        // Fill, then clear together with a write that must be dropped
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1, 3'(i), 8'h80 + 8'(i), 0, 0, 0, 0);
        end
        applyStimulus(0, 0, 8'h00, 1, 3'd4, 3'd6, 0);
        checkOutput("fill_dataA", data_a_out, 8'h84);
        checkOutput("fill_dataB", data_b_out, 8'h86);
        applyStimulus(1, 3'd1, 8'hFF, 0, 0, 0, 1);
        for (int i = 0; i < 8; i++) begin
            checkOutput($sformatf("clr_busy%0d", i), {7'd0, busy_out}, 8'h01);
            checkOutput($sformatf("clr_valid%0d", i), {7'd0, rd_valid_out}, 8'h00);
            checkOutput($sformatf("clr_dataA%0d", i), data_a_out, 8'h00);
            applyStimulus(1, 3'd1, 8'hFF, 1, 3'd1, 3'd7, (i == 3));
        end
        checkOutput("clr_busy_end", {7'd0, busy_out}, 8'h00);
        checkOutput("clr_valid_end", {7'd0, rd_valid_out}, 8'h00);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(0, 0, 8'h00, 1, 3'(i), 3'(7 - i), 0);
            checkOutput($sformatf("postclr_valid%0d", i), {7'd0, rd_valid_out}, 8'h01);
            checkOutput($sformatf("postclr_A%0d", i), data_a_out, 8'h00);
            checkOutput($sformatf("postclr_B%0d", i), data_b_out, 8'h00);
        end

        // Reset during the 4th busy cycle
        applyStimulus(1, 3'd0, 8'h5B, 0, 0, 0, 0);
        applyStimulus(1, 3'd6, 8'h5A, 0, 0, 0, 0);
        applyStimulus(0, 0, 8'h00, 0, 0, 0, 1);
        checkOutput("rstclr_busy1", {7'd0, busy_out}, 8'h01);
        applyStimulus(0, 0, 8'h00, 0, 0, 0, 0);
        applyStimulus(0, 0, 8'h00, 0, 0, 0, 0);
        applyStimulus(0, 0, 8'h00, 0, 0, 0, 0);
        checkOutput("rstclr_busy4", {7'd0, busy_out}, 8'h01);
        rst_in = 1'b1;
        applyStimulus(0, 0, 8'h00, 0, 0, 0, 0);
        rst_in = 1'b0;
        checkOutput("rstclr_busy", {7'd0, busy_out}, 8'h00);
        checkOutput("rstclr_valid", {7'd0, rd_valid_out}, 8'h00);
        applyStimulus(0, 0, 8'h00, 1, 3'd6, 3'd0, 0);
        checkOutput("rstclr_A6", data_a_out, 8'h00);
        checkOutput("rstclr_B0", data_b_out, 8'h00);

        // In-flight read discarded by reset
        applyStimulus(1, 3'd4, 8'h44, 0, 0, 0, 0);
        rst_in = 1'b1;
        applyStimulus(0, 0, 8'h00, 1, 3'd4, 3'd4, 0);
        rst_in = 1'b0;
        checkOutput("inflight_valid", {7'd0, rd_valid_out}, 8'h00);
        checkOutput("inflight_dataA", data_a_out, 8'h00);

        // Six-entry instance: out-of-range write ignored and read returns zero
        doReset();
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1, 3'(i), 8'h10 + 8'(i), 0, 0, 0, 0);
        end
        applyStimulus(1, 3'd6, 8'h77, 0, 0, 0, 0);
        applyStimulus(0, 0, 8'h00, 1, 3'd6, 3'd7, 0);
        checkOutput("d6_valid", {7'd0, d6Valid}, 8'h01);
        checkOutput("d6_A6", d6A, 8'h00);
        checkOutput("d6_B7", d6B, 8'h00);
        checkOutput("d8_A6", data_a_out, 8'h77);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 0, 8'h00, 1, 3'(2 * i), 3'(2 * i + 1), 0);
            checkOutput($sformatf("d6_A%0d", 2 * i), d6A, 8'h10 + 8'(2 * i));
            checkOutput($sformatf("d6_B%0d", 2 * i + 1), d6B, 8'h11 + 8'(2 * i));
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
